execute: RTL and testbench

- Integer execute unit of the single-cycle processor datapath.
- Takes decoded register operands, immediates and control flags from decode.
- Produces the ALU result (arithmetic, logic, address, compare difference, MVHI merge) and a 1-bit branch/compare condition.
- Outputs are combinational for same-cycle use, plus a registered copy of each for pipelined consumers.

---
 rtl/execute.sv | 122 ++++++++++++
 tb/tb_execute.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/execute.sv
// Integer execute unit: operand-B selection, ALU, MVHI merge and signed
// branch/compare condition. Results are produced combinationally for
// same-cycle use and also registered for pipelined consumers.
module execute #(
  parameter int OP_BIT_WIDTH = 4,
  parameter int DBITS        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DBITS-1:0]        inRegd,
  input  logic [DBITS-1:0]        inReg1,
  input  logic [DBITS-1:0]        inReg2,
  input  logic [DBITS-1:0]        imm32,
  input  logic [15:0]             immHi,
  input  logic                    useZero,
  input  logic                    useImm,
  input  logic                    isMvhi,
  input  logic                    isBranchOrCond,
  input  logic [OP_BIT_WIDTH-1:0] opAlu,
  input  logic [OP_BIT_WIDTH-1:0] opCond,
  output logic [DBITS-1:0]        outAlu,
  output logic                    outCond,
  output logic [DBITS-1:0]        outAluQ,
  output logic                    outCondQ
);

  // ALU function codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NAND = 4'b1100;
  localparam logic [3:0] ALU_NOR  = 4'b1101;
  localparam logic [3:0] ALU_XNOR = 4'b1110;

  // Base condition selected by opCond[1:0]
  localparam logic [1:0] CND_F  = 2'b00;
  localparam logic [1:0] CND_EQ = 2'b01;
  localparam logic [1:0] CND_LT = 2'b10;
  localparam logic [1:0] CND_LE = 2'b11;

  logic [DBITS-1:0] op_a_s;
  logic [DBITS-1:0] op_b_s;
  logic [DBITS-1:0] alu_s;
  logic             base_cond_s;
  logic             cond_s;
  logic             unused_ok_s;

  // Signed less-than done with a true signed comparison so that operand
  // pairs whose difference overflows still order correctly.
  function automatic logic signed_lt(input logic [DBITS-1:0] a,
                                     input logic [DBITS-1:0] b);
    return ($signed(a) < $signed(b));
  endfunction

  assign op_a_s = inReg1;

  // opCond[2] only distinguishes zero-compare variants, which decode already
  // expresses by forcing operand B to zero.
  assign unused_ok_s = &{1'b1, opCond[2]};

  // Operand B select: zero has priority over immediate, register is fallback
  always_comb begin
    op_b_s = {DBITS{1'b0}};
    if (useZero) begin
      op_b_s = {DBITS{1'b0}};
    end else if (useImm) begin
      op_b_s = imm32;
    end else begin
      op_b_s = inReg2;
    end
  end

  // ALU function decode; MVHI merge overrides every ALU code
  always_comb begin
    alu_s = {DBITS{1'b0}};
    if (isMvhi) begin
      alu_s = {immHi, inRegd[DBITS-17:0]};
    end else begin
      case (opAlu[3:0])
        ALU_ADD:  alu_s = op_a_s + op_b_s;
        ALU_SUB:  alu_s = op_a_s - op_b_s;
        ALU_AND:  alu_s = op_a_s & op_b_s;
        ALU_OR:   alu_s = op_a_s | op_b_s;
        ALU_XOR:  alu_s = op_a_s ^ op_b_s;
        ALU_NAND: alu_s = ~(op_a_s & op_b_s);
        ALU_NOR:  alu_s = ~(op_a_s | op_b_s);
        ALU_XNOR: alu_s = ~(op_a_s ^ op_b_s);
        default:  alu_s = {DBITS{1'b0}};
      endcase
    end
  end

  // Condition evaluation: base compare, optional inversion, gated by class
  always_comb begin
    base_cond_s = 1'b0;
    case (opCond[1:0])
      CND_F:   base_cond_s = 1'b0;
      CND_EQ:  base_cond_s = (op_a_s == op_b_s);
      CND_LT:  base_cond_s = signed_lt(op_a_s, op_b_s);
      CND_LE:  base_cond_s = signed_lt(op_a_s, op_b_s) | (op_a_s == op_b_s);
      default: base_cond_s = 1'b0;
    endcase
    cond_s = isBranchOrCond & (base_cond_s ^ opCond[3]);
  end

  assign outAlu  = alu_s;
  assign outCond = cond_s;

  // Pipeline copy of the results; async reset clears the registered copy only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outAluQ  <= {DBITS{1'b0}};
      outCondQ <= 1'b0;
    end else begin
      outAluQ  <= alu_s;
      outCondQ <= cond_s;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute unit.
module tb_execute;

  logic        clk;
  logic        reset;
  logic [31:0] inRegd, inReg1, inReg2, imm32;
  logic [15:0] immHi;
  logic        useZero, useImm, isMvhi, isBranchOrCond;
  logic [3:0]  opAlu, opCond;
  logic [31:0] outAlu, outAluQ;
  logic        outCond, outCondQ;

  int checks;
  int failures;

  execute #(.OP_BIT_WIDTH(4), .DBITS(32)) dut (
    .clk(clk), .reset(reset),
    .inRegd(inRegd), .inReg1(inReg1), .inReg2(inReg2), .imm32(imm32),
    .immHi(immHi), .useZero(useZero), .useImm(useImm), .isMvhi(isMvhi),
    .isBranchOrCond(isBranchOrCond), .opAlu(opAlu), .opCond(opCond),
    .outAlu(outAlu), .outCond(outCond), .outAluQ(outAluQ), .outCondQ(outCondQ)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] alu, input logic [3:0] cnd,
                        input logic uimm, input logic uzero,
                        input logic br, input logic mvhi);
    opAlu = alu; opCond = cnd; useImm = uimm; useZero = uzero;
    isBranchOrCond = br; isMvhi = mvhi;
  endtask

  task automatic chk_comb(input string tag, input logic [31:0] exp_alu, input logic exp_cond);
    #1;
    chk({tag, "_alu"}, outAlu, exp_alu);
    chk({tag, "_cond"}, {31'd0, outCond}, {31'd0, exp_cond});
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0;
    inRegd = 32'h0000_1111; inReg1 = 32'd8; inReg2 = 32'd3; imm32 = 32'd1; immHi = 16'h2222;
    set_op(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst_aluq", outAluQ, 32'd0);
    chk("rst_condq", {31'd0, outCondQ}, 32'd0);

    // Register ALU ops
    set_op(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); chk_comb("add_r", 32'd11, 1'b0);
    set_op(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); chk_comb("sub_r", 32'd5, 1'b0);
    set_op(4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); chk_comb("xor_r", 32'd11, 1'b0);
    set_op(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); chk_comb("and_r", 32'd0, 1'b0);
    set_op(4'b1100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); chk_comb("nand_r", 32'hFFFF_FFFF, 1'b0);
    set_op(4'b1101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); chk_comb("nor_r", 32'hFFFF_FFF4, 1'b0);
    set_op(4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); chk_comb("xnor_r", 32'hFFFF_FFF4, 1'b0);
    set_op(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); chk_comb("undef_op", 32'd0, 1'b0);
    // A non-branch instruction must not raise outCond even with a true condition code
    set_op(4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0); chk_comb("cond_gated", 32'd11, 1'b0);

    // Immediate ALU ops and address generation
    set_op(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0); chk_comb("add_i", 32'd9, 1'b0);
    set_op(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0); chk_comb("sub_i", 32'd7, 1'b0);
    set_op(4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0); chk_comb("or_i", 32'd9, 1'b0);
    set_op(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0); chk_comb("addr", 32'd9, 1'b0);
    // useZero outranks useImm
    set_op(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0); chk_comb("zero_prio", 32'd8, 1'b0);

    // Compares and branches
    set_op(4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("cmp_lt", 32'd5, 1'b0);
    set_op(4'b0001, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("cmp_gte", 32'd5, 1'b1);
    set_op(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0); chk_comb("cmpi_f", 32'd7, 1'b0);
    set_op(4'b0001, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0); chk_comb("cmpi_t", 32'd7, 1'b1);
    set_op(4'b0001, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("br_lte", 32'd5, 1'b0);
    set_op(4'b0001, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("br_gt", 32'd5, 1'b1);
    set_op(4'b0001, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0); chk_comb("br_gtz", 32'd8, 1'b1);

    // MVHI
    set_op(4'b1011, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1); chk_comb("mvhi", 32'h2222_1111, 1'b0);

    // Signed edges: differences that overflow
    inReg1 = 32'h8000_0000; inReg2 = 32'd1;
    set_op(4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("lt_min", 32'h7FFF_FFFF, 1'b1);
    inReg1 = 32'h7FFF_FFFF; inReg2 = 32'hFFFF_FFFF;
    set_op(4'b0001, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("lt_max", 32'h8000_0000, 1'b0);
    set_op(4'b0001, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("gt_max", 32'h8000_0000, 1'b1);
    inReg1 = 32'h8000_0000; inReg2 = 32'h8000_0000;
    set_op(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("eq", 32'd0, 1'b1);
    set_op(4'b0001, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("ne", 32'd0, 1'b0);
    set_op(4'b0001, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0); chk_comb("lte_eq", 32'd0, 1'b1);

    // Registered outputs
    inReg1 = 32'd8; inReg2 = 32'd3;
    @(negedge clk);
    chk("rst_hold_aluq", outAluQ, 32'd0);
    reset = 1'b0;
    set_op(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("q1_alu", outAluQ, 32'd11);
    chk("q1_cond", {31'd0, outCondQ}, 32'd0);
    @(negedge clk);
    set_op(4'b0001, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("q2_alu", outAluQ, 32'd5);
    chk("q2_cond", {31'd0, outCondQ}, 32'd1);
    @(negedge clk);
    set_op(4'b1011, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("q3_alu", outAluQ, 32'h2222_1111);
    chk("q3_cond", {31'd0, outCondQ}, 32'd0);
    @(negedge clk);
    set_op(4'b0001, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("q4_alu", outAluQ, 32'd5);
    chk("q4_cond", {31'd0, outCondQ}, 32'd1);

    // Mid-run reset pulse, asserted away from any clock edge
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_aluq", outAluQ, 32'd0);
    chk("mrst_condq", {31'd0, outCondQ}, 32'd0);
    chk("mrst_comb_alu", outAlu, 32'd5);
    chk("mrst_comb_cond", {31'd0, outCond}, 32'd1);
    @(posedge clk); #1;
    chk("mrst_hold_aluq", outAluQ, 32'd0);
    chk("mrst_hold_condq", {31'd0, outCondQ}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_aluq", outAluQ, 32'd0);
    @(posedge clk); #1;
    chk("rel_q_alu", outAluQ, 32'd5);
    chk("rel_q_cond", {31'd0, outCondQ}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
